mem_arbiter: RTL

//  Shares the single unified instruction/data memory between the multicycle core and an

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_wait_ctr.sv | 29 ++
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM state encoding,
// grant identifiers and the wait-counter width helper.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CORE_ACC = 2'd1,
        EXT_ACC  = 2'd2
    } arb_state_t;

    localparam logic GNT_CORE = 1'b0;
    localparam logic GNT_EXT  = 1'b1;

    // Width of a counter holding 0..wait_cycles; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_wait_ctr.sv
// Loadable down-counter with zero flag. Sequences the wait states of one
// memory access; holds at zero when not decrementing.
module mem_arb_wait_ctr #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] cnt;

    // Load takes priority; decrement stops at zero so the flag stays stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter between the multicycle core and the external loader/debug port for
// the single unified memory. Each access takes WAIT_CYCLES+1 memory cycles
// followed by a registered done pulse; ties alternate between requesters.
// Optional feature: define MEM_ARB_STALLCNT_EN to add a saturating stall_cnt
// output counting the cycles core_stall is high.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_adr,
    input  logic [DW-1:0] core_wd,
    output logic [DW-1:0] core_rd,
    output logic          core_done,
    output logic          core_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_adr,
    input  logic [DW-1:0] ext_wd,
    output logic [DW-1:0] ext_rd,
    output logic          ext_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
`ifdef MEM_ARB_STALLCNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    import mem_arb_pkg::*;

    localparam int unsigned     CW        = cnt_width(WAIT_CYCLES);
    localparam logic [CW-1:0]   WAIT_LOAD = CW'(WAIT_CYCLES);

    arb_state_t state;
    logic       last_gnt;
    logic       grant_core;
    logic       grant_ext;
    logic       wcnt_zero;

    // Arbitration in IDLE: lone requester wins, a tie goes to the port not served last.
    always_comb begin
        grant_core = 1'b0;
        grant_ext  = 1'b0;
        if (state == IDLE) begin
            if (core_req && ext_req) begin
                if (last_gnt == GNT_EXT) begin
                    grant_core = 1'b1;
                end else begin
                    grant_ext = 1'b1;
                end
            end else if (core_req) begin
                grant_core = 1'b1;
            end else if (ext_req) begin
                grant_ext = 1'b1;
            end
        end
    end

    mem_arb_wait_ctr #(
        .WIDTH (CW)
    ) u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (grant_core | grant_ext),
        .load_val (WAIT_LOAD),
        .dec      (state != IDLE),
        .zero     (wcnt_zero)
    );

    // Main FSM with registered read data and done pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            last_gnt  <= GNT_EXT;
            core_rd   <= '0;
            ext_rd    <= '0;
            core_done <= 1'b0;
            ext_done  <= 1'b0;
        end else begin
            core_done <= 1'b0;
            ext_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_core) begin
                        state    <= CORE_ACC;
                        last_gnt <= GNT_CORE;
                    end else if (grant_ext) begin
                        state    <= EXT_ACC;
                        last_gnt <= GNT_EXT;
                    end
                end
                CORE_ACC: begin
                    if (wcnt_zero) begin
                        if (!core_we) begin
                            core_rd <= mem_rd;
                        end
                        core_done <= 1'b1;
                        state     <= IDLE;
                    end
                end
                EXT_ACC: begin
                    if (wcnt_zero) begin
                        if (!ext_we) begin
                            ext_rd <= mem_rd;
                        end
                        ext_done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Memory-side mux; core path is the idle default so the address is never floating.
    always_comb begin
        mem_en  = (state == CORE_ACC) || (state == EXT_ACC);
        mem_we  = ((state == CORE_ACC) && core_we) || ((state == EXT_ACC) && ext_we);
        mem_adr = (state == EXT_ACC) ? ext_adr : core_adr;
        mem_wd  = (state == EXT_ACC) ? ext_wd  : core_wd;
    end

    assign core_stall = core_req & ~core_done;

`ifdef MEM_ARB_STALLCNT_EN
    // Saturating count of core stall cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (core_stall && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
